// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings, Hack jump-field bit positions.
package pc_sequencer_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  // Hack C-instruction marker and jump-field bit indices
  localparam int unsigned C_BIT = 15;
  localparam int unsigned J_LT  = 2;
  localparam int unsigned J_EQ  = 1;
  localparam int unsigned J_GT  = 0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Hack jump-condition decode: take is high when a C-instruction's jump bits match the ALU flags.
module pc_sequencer_jump_cond
  import pc_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               zr,
  input  logic               ng,
  output logic               take
);

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[C_BIT-1:J_LT+1];

  assign take = instr[C_BIT] & ((instr[J_LT] & ng) |
                                (instr[J_EQ] & zr) |
                                (instr[J_GT] & ~ng & ~zr));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning every PC update; optional debug stepping via PC_SEQ_SINGLE_STEP_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 0,
  parameter int unsigned TO_W          = 8,
  parameter int unsigned HALT_DETECT   = 1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               rom_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  a_reg,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               zr,
  input  logic               ng,
  output logic               fetch_req,
  output logic               exec_en,
  output logic               pc_load,
  output logic               pc_inc,
  output logic               pc_clr,
  output logic               halted,
  output logic               fault
);

  localparam logic            TO_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
  localparam logic            HALT_EN = (HALT_DETECT != 0);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic            take;
  logic            fetch_go;
  logic            fetch_hold;

  pc_sequencer_jump_cond u_jump_cond (
    .instr (instr),
    .zr    (zr),
    .ng    (ng),
    .take  (take)
  );

  // A ready-but-unstepped ROM holds FETCH and freezes the timeout counter
`ifdef PC_SEQ_SINGLE_STEP_EN
  assign fetch_go   = rom_ready & step;
  assign fetch_hold = rom_ready & ~step;
`else
  assign fetch_go   = rom_ready;
  assign fetch_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      to_cnt_q <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    fetch_req = 1'b0;
    exec_en   = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        pc_clr  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_go) begin
          state_d  = ST_EXEC;
          to_cnt_d = '0;
        end else if (!fetch_hold) begin
          if (TO_EN && (to_cnt_q == TO_LAST)) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        pc_load = take;
        pc_inc  = ~take;
        // A taken jump to its own address can never make progress
        if (HALT_EN && take && (a_reg == pc)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign halted = halted_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural phase model plus directed literal checks.
module tb_pc_sequencer;

  localparam int TO = 4;
  localparam int P_INIT = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_ready, zr, ng;
  logic [15:0] instr, a_reg;
  logic [15:0] pc_r = 16'hFFFF;
  logic [15:0] pc_nxt = 16'hFFFF;
  logic        fetch_req, exec_en, pc_load, pc_inc, pc_clr, halted, fault;
  logic        step_v;
  logic [15:0] rom [32];

`ifdef PC_SEQ_SINGLE_STEP_EN
  logic step;
  assign step_v = step;
`else
  assign step_v = 1'b1;
`endif

  int checks = 0;
  int failures = 0;

  int   m_ph = P_INIT, n_ph = P_INIT;
  int   m_wt = 0, n_wt = 0;
  logic m_h = 1'b0, n_h = 1'b0, m_f = 1'b0, n_f = 1'b0;

  pc_sequencer #(.FETCH_TIMEOUT(TO), .TO_W(8), .HALT_DETECT(1)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PC_SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .rom_ready (rom_ready),
    .instr     (instr),
    .a_reg     (a_reg),
    .pc        (pc_r),
    .zr        (zr),
    .ng        (ng),
    .fetch_req (fetch_req),
    .exec_en   (exec_en),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .pc_clr    (pc_clr),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  assign instr = rom[pc_r[4:0]];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Jump decision from the ALU result's sign/zero relation
  function automatic logic m_take(input logic [15:0] ins, input logic z, input logic n);
    logic lt, eq, gt;
    lt = n;
    eq = z;
    gt = !n && !z;
    if (!ins[15]) return 1'b0;
    return (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
  endfunction

  // Per-cycle compare against the model, then compute next model and PC values
  always @(negedge clk) begin
    logic       tk;
    logic [6:0] exp_v;
    tk = m_take(instr, zr, ng);
    exp_v = {m_ph == P_INIT, m_ph == P_FETCH, m_ph == P_EXEC,
             (m_ph == P_EXEC) && tk, (m_ph == P_EXEC) && !tk, m_h, m_f};
    check("cycle_outputs", 16'({pc_clr, fetch_req, exec_en, pc_load, pc_inc, halted, fault}),
          16'(exp_v));
    n_ph = m_ph; n_wt = m_wt; n_h = m_h; n_f = m_f;
    case (m_ph)
      P_INIT:  n_ph = P_FETCH;
      P_FETCH: begin
        if (rom_ready && step_v) begin
          n_ph = P_EXEC;
          n_wt = 0;
        end else if (!rom_ready) begin
          if (m_wt + 1 == TO) begin
            n_ph = P_HALT;
            n_f  = 1'b1;
          end else begin
            n_wt = m_wt + 1;
          end
        end
      end
      P_EXEC: begin
        if (tk && (a_reg == pc_r)) begin
          n_ph = P_HALT;
          n_h  = 1'b1;
        end else begin
          n_ph = P_FETCH;
        end
      end
      default: n_ph = P_HALT;
    endcase
    if (pc_clr)       pc_nxt = 16'h0000;
    else if (pc_load) pc_nxt = a_reg;
    else if (pc_inc)  pc_nxt = pc_r + 16'h0001;
    else              pc_nxt = pc_r;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= P_INIT; m_wt <= 0; m_h <= 1'b0; m_f <= 1'b0;
    end else begin
      m_ph <= n_ph; m_wt <= n_wt; m_h <= n_h; m_f <= n_f;
    end
  end

  always @(posedge clk) pc_r <= pc_nxt;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0005;
    rom[1]  = 16'h0007;
    rom[2]  = 16'hE302;
    rom[3]  = 16'hE302;
    rom[4]  = 16'hEA87;
    rom[16] = 16'hE302;
    rom[17] = 16'hEA87;
    rom_ready = 1'b1; zr = 1'b0; ng = 1'b0; a_reg = 16'h0010;
`ifdef PC_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif

    // Reset state
    repeat (2) cyc();
    check("rst_pc_clr", 16'(pc_clr), 16'h1);
    check("rst_fetch_req", 16'(fetch_req), 16'h0);
    check("rst_flags", 16'({halted, fault}), 16'h0);
    reset = 1'b0;
    #1 check("init_cycle_pc_clr", 16'(pc_clr), 16'h1);

    // Two A-instructions, zero-wait ROM
    cyc(); check("f0_req", 16'({fetch_req, exec_en}), 16'h2); check("f0_pc", pc_r, 16'h0000);
    cyc(); check("e0_inc", 16'({exec_en, pc_inc, pc_load}), 16'h6);
    cyc(); check("f1_pc", pc_r, 16'h0001);
    cyc(); check("e1_inc", 16'({exec_en, pc_inc}), 16'h3);
    cyc(); check("f2_pc", pc_r, 16'h0002); zr = 1'b1;
    // JEQ taken
    cyc(); check("jeq_taken", 16'({pc_load, pc_inc}), 16'h2);
    cyc(); check("jeq_target", pc_r, 16'h0010); zr = 1'b0;
    // JEQ not taken
    cyc(); check("jeq_not_taken", 16'({pc_load, pc_inc}), 16'h1);
    cyc(); check("jeq_fall", pc_r, 16'h0011); a_reg = 16'h0003;
    cyc(); check("jmp_load", 16'(pc_load), 16'h1);
    cyc(); check("jmp_target", pc_r, 16'h0003);
    // Conditional self-jump not taken: increments, no halt
    cyc(); check("cond_self_inc", 16'({pc_inc, halted}), 16'h2);
    cyc(); check("pc_4", pc_r, 16'h0004); a_reg = 16'h0004;
    // Unconditional self-jump halts
    cyc(); check("self_jmp_load", 16'(pc_load), 16'h1);
    cyc(); check("halt_flag", 16'({halted, fetch_req, fault}), 16'h4);
    check("halt_pc", pc_r, 16'h0004);
    repeat (5) cyc();
    check("halt_stays", 16'({halted, fetch_req, exec_en}), 16'h4);

    // Fetch timeout: ROM never ready
    rom_ready = 1'b0; reset = 1'b1;
    cyc(); reset = 1'b0;
    #1 check("to_cleared", 16'({halted, fault, pc_clr}), 16'h1);
    for (int i = 0; i < TO; i++) begin
      cyc(); check("to_fetch_wait", 16'({fetch_req, exec_en}), 16'h2);
    end
    cyc(); check("to_fault", 16'({fault, halted, fetch_req}), 16'h4);

    // Ready arrives on the third FETCH cycle: no fault
    reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc(); cyc();
    cyc(); rom_ready = 1'b1; #1 check("late_ready_fetch", 16'(fetch_req), 16'h1);
    cyc(); check("late_ready_exec", 16'({exec_en, pc_inc, fault}), 16'h6);
    cyc(); check("late_pc1", pc_r, 16'h0001);
    cyc();
    cyc(); check("late_pc2", pc_r, 16'h0002); zr = 1'b1; a_reg = 16'h0010;

    // Asynchronous reset in EXEC of a taken jump
    cyc(); check("pre_rst_load", 16'(pc_load), 16'h1);
    #1 reset = 1'b1;
    #1 check("async_rst_drop", 16'({pc_load, exec_en, pc_clr}), 16'h1);
    cyc(); check("rst_pc_cleared", pc_r, 16'h0000);
    reset = 1'b0; zr = 1'b0;
    cyc(); check("restart_fetch", 16'(fetch_req), 16'h1); check("restart_pc", pc_r, 16'h0000);
    cyc(); check("restart_exec", 16'({exec_en, pc_inc}), 16'h3);
    cyc(); check("restart_pc1", pc_r, 16'h0001);

`ifdef PC_SEQ_SINGLE_STEP_EN
    // Debug stepping: ready but no step holds FETCH indefinitely
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(); check("step_hold", 16'({fetch_req, exec_en, fault}), 16'h4);
    end
    step = 1'b1;
    cyc(); check("step_exec", 16'(exec_en), 16'h1); step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); check("step_single", 16'(exec_en), 16'h0);
    end
    check("step_pc", pc_r, 16'h0002);
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute controller for the 16-bit program counter. It drives the PC's load, inc and reset controls, handshakes instruction fetch with ROM, decodes the Hack jump field against ALU flags, and detects halt (self-jump).
- Sits between the instruction ROM, the CPU datapath (A register, ALU flags) and the PC counter. It owns every PC update decision.

Parameters:
- FETCH_TIMEOUT, 0, max cycles FETCH may wait for rom_ready; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; FETCH_TIMEOUT < 2**TO_W.
- HALT_DETECT, 1, 1 enables self-jump halt detection.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_ready  in  1  instr valid for the current pc this cycle.
- instr  in  16  instruction word from ROM.
- a_reg  in  16  current A register value (jump target).
- pc  in  16  current PC output (used for halt compare).
- zr  in  1  ALU zero flag for the current instr.
- ng  in  1  ALU negative flag for the current instr.
- fetch_req  out  1  request instruction at pc.
- exec_en  out  1  one-cycle commit strobe for datapath writes.
- pc_load  out  1  PC load (target = a_reg).
- pc_inc  out  1  PC increment.
- pc_clr  out  1  drives PC reset input.
- halted  out  1  sticky halt indication.
- fault  out  1  sticky fetch-timeout fault.

Behaviour:
- States: INIT, FETCH, EXEC, HALT. Binary-encoded, registered.
- Async reset: state=INIT; timeout counter=0; halted=0; fault=0. All outputs are combinational from state and inputs, so they read 0 except pc_clr=1.
- INIT (1 cycle): pc_clr=1, others 0. Next state FETCH. The PC is therefore 0 on entry to the first FETCH.
- FETCH: fetch_req=1.
  - rom_ready=1: next state EXEC; counter cleared.
  - rom_ready=0: counter increments.
  - FETCH_TIMEOUT≠0 and counter==FETCH_TIMEOUT-1 without ready: next state HALT, fault set.
- EXEC (exactly 1 cycle): exec_en=1.
  - instr, zr and ng must be held stable by the datapath this cycle.
  - take = instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr)).
  - take=1: pc_load=1, pc_inc=0. Otherwise pc_inc=1.
  - pc_load and pc_inc are never both 1.
  - Next state FETCH, except that HALT_DETECT=1 and take=1 and a_reg==pc give next state HALT with halted set.
- HALT: all strobes 0. Left only by reset. halted and fault hold.
- PC update latency: the PC changes on the clk edge that ends EXEC. Throughput: 2 cycles per instruction with zero-wait ROM.
- A-instruction (instr[15]=0): never a jump; j bits ignored.
- Conditional self-jump not taken: normal increment, no halt.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to INIT. The in-flight instruction is not committed.
- pc wrap: 0xFFFF increments to 0x0000 in the PC. No special handling here.

Optional Feature:
- Macro: PC_SEQ_SINGLE_STEP_EN.
- Defined: adds input step (1 bit).
  - EXEC is entered from FETCH only when rom_ready=1 and step=1. Otherwise FETCH holds with fetch_req=1.
  - The timeout counter is frozen while rom_ready=1 and step=0.
  - Intended for debug stepping.
- Not defined: the port is absent and EXEC follows rom_ready alone.

Decomposition:
- Shared include pc_seq_defs.vh holds:
  - state encodings ST_INIT, ST_FETCH, ST_EXEC, ST_HALT;
  - jump-field bit indices J_LT=2, J_EQ=1, J_GT=0;
  - C-instruction marker bit index 15.
- One combinational sub-module, jump_cond: inputs instr, zr, ng; output take. It is reused by the CPU for trace.

Test Plan:
- Reset, then ROM always ready with A-instrs 0x0005, 0x0007 → pc_clr in cycle 1; fetch_req and exec_en alternate; pc_inc pulses; PC goes 0→1→2.
- C-instr 0xE302 (JEQ) with zr=1, a_reg=0x0010 → pc_load=1 in EXEC, PC=0x0010. Same with zr=0 → pc_inc, PC+1.
- At pc=0x0004, a_reg=0x0004, instr 0xEA87 (0;JMP) → HALT next cycle; halted=1; no further fetch_req until reset.
- FETCH_TIMEOUT=4, rom_ready held 0 → HALT after 4 FETCH cycles, fault=1. With rom_ready=1 on cycle 3, normal EXEC and fault=0.
- Reset pulsed asynchronously mid-EXEC of a taken jump → pc_load drops immediately, state INIT, pc_clr=1. Restart fetches from 0.
- With PC_SEQ_SINGLE_STEP_EN, rom_ready=1 and step=0 for 10 cycles → no exec_en. A single step pulse → exactly one EXEC.
